mult_share_arbiter: RTL and testbench
=====================================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 Parameter OP_W, default 16, operand width; product width is 2*OP_W.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles in WAIT before the job is aborted.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester job request, held until accepted.
REQ-007 req_a  input  NUM_REQ*OP_W  packed operand A; slice i belongs to requester i.
REQ-008 req_b  input  NUM_REQ*OP_W  packed operand B; slice i belongs to requester i.
REQ-009 req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-010 rsp_valid  output  NUM_REQ  one-hot result valid.
REQ-011 rsp_ready  input  NUM_REQ  per-requester result accept.
REQ-012 rsp_product  output  2*OP_W  result; meaningful only while any rsp_valid is high.
REQ-013 rsp_err  output  1  qualifies rsp_product as aborted by timeout.
REQ-014 mul_start  output  1  start pulse to the shared multiplier.
REQ-015 mul_a, mul_b  output  OP_W each  operands to the multiplier.
REQ-016 mul_product  input  2*OP_W  multiplier result.
REQ-017 mul_done  input  1  multiplier completion.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: when any req_valid is high, grant one round-robin winner i, starting the search at pointer rr_ptr.
  - Assert req_ready[i] for exactly that cycle.
  - Latch req_a/req_b slice i into operand registers and latch i as owner.
  - Go to ISSUE.
REQ-021 req_ready may be high only in IDLE, for the granted index, and only while req_valid of that index is high.
REQ-022 ISSUE: assert mul_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-023 mul_a/mul_b equal the latched operands from ISSUE through the end of WAIT; they are 0 in IDLE.
REQ-024 WAIT: mul_done is sampled only in this state, and mul_done during ISSUE is ignored.
  - On mul_done=1, capture mul_product, set rsp_err=0 and go to RESP.
REQ-025 WAIT timeout: when the counter reaches TIMEOUT-1 without mul_done, capture product 0, set rsp_err=1 and go to RESP.
REQ-026 RESP: assert rsp_valid[owner] and hold rsp_product/rsp_err stable until rsp_ready[owner]=1.
  - On that handshake: rr_ptr <= (owner+1) mod NUM_REQ, then go to IDLE.
REQ-027 rsp_ready of non-owners is ignored, and rsp_valid never has more than one bit set.
REQ-028 New requests arriving in non-IDLE states wait; there is no queuing, at most one job is in flight.
REQ-029 Minimum latency is grant cycle to rsp_valid = 2 + multiplier cycles (grant, ISSUE, then WAIT until done) + 1.
REQ-030 Back-to-back operation: a request that is valid in the IDLE cycle following a RESP handshake is granted in that same cycle.

Reset
REQ-031 On rst=1, asynchronously:
  - state=IDLE, rr_ptr=0, owner=0;
  - operand, product and counter registers = 0;
  - all outputs 0.
REQ-032 Reset mid-job abandons the job with no response; the multiplier shares the same reset.

Structure
REQ-033 Package mult_pkg holds the FSM state enum, the OP_W default and the TIMEOUT default.
REQ-034 Sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant and index) is instantiated once.
  - It has no internal state; the pointer is owned by mult_share_arbiter.

Verification
REQ-035 Single job: req0 valid, A=3, B=5.
  - Expect req_ready[0] for 1 cycle, then a mul_start pulse, then rsp_valid[0] with product 15 and err 0.
REQ-036 Contention: req0..req3 all valid from reset, each answering immediately.
  - Expect grant order 0,1,2,3,0, and each rsp to carry its own product (e.g. 0xFFFF*0xFFFF=0xFFFE0001 on req3).
REQ-037 Response backpressure: rsp_ready[1] held low 10 cycles.
  - Expect rsp_valid[1] and rsp_product stable for all 10 cycles, and no new grant until the handshake.
REQ-038 Timeout: mul_done tied low.
  - Expect rsp_valid after TIMEOUT cycles in WAIT, with rsp_err=1 and product 0, then the next requester granted.
REQ-039 Reset mid-WAIT: rst pulsed.
  - Expect all outputs 0 immediately, and the next grant to start from requester 0.

Source files
------------

// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the multiplier-sharing arbiter: the job FSM state
// encoding and the default operand width / WAIT timeout used by the top.
// ----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int OP_W_DEF    = 16;
  localparam int TIMEOUT_DEF = 64;

endpackage : mult_pkg

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts at `ptr` and
// wraps; the first asserted request wins. The pointer lives in the parent.
//
// Ports
//   req        in   NUM_REQ  request vector
//   ptr        in   IDX_W    index that has highest priority this cycle
//   grant      out  NUM_REQ  one-hot winner (all zero when no request)
//   grant_idx  out  IDX_W    binary index of the winner
//   grant_vld  out  1        any request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] cand;

  // NOTE: every signal written here gets a default first, so no path through
  // the loop leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!grant_vld && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_vld   = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/mult_share_arbiter.sv
// ----------------------------------------------------------------------------
// mult_share_arbiter
// Shares one external multiplier among NUM_REQ requesters. One job is in
// flight at a time: IDLE grants a round-robin winner, ISSUE pulses the
// multiplier start, WAIT collects the product (or aborts after TIMEOUT
// cycles), RESP holds the result for the owner until it is accepted.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_a/req_b    per-requester job request and packed operands
//   req_ready                one-hot accept strobe (IDLE only)
//   rsp_valid/rsp_ready      one-hot result valid, per-requester accept
//   rsp_product/rsp_err      result and timeout-abort flag
//   mul_start/mul_a/mul_b    command to the shared multiplier
//   mul_product/mul_done     multiplier result and completion
//   busy                     high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = OP_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [2*OP_W-1:0]       rsp_product,
  output logic                    rsp_err,
  output logic                    mul_start,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  input  logic [2*OP_W-1:0]       mul_product,
  input  logic                    mul_done,
  output logic                    busy
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;
  localparam int PROD_W = 2 * OP_W;

  state_e               state_q,     state_d;
  logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0]     owner_q,     owner_d;
  logic [OP_W-1:0]      op_a_q,      op_a_d;
  logic [OP_W-1:0]      op_b_q,      op_b_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [PROD_W-1:0]    prod_q,      prod_d;
  logic                 err_q,       err_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic                 mul_start_q, mul_start_d;

  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_vld;
  logic [NUM_REQ-1:0]   owner_oh;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    mul_start_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          owner_d     = grant_idx;
          op_a_d      = req_a[int'(grant_idx)*OP_W +: OP_W];
          op_b_d      = req_b[int'(grant_idx)*OP_W +: OP_W];
          // Start is registered, so raising it here makes it high exactly
          // for the ISSUE cycle.
          mul_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion in the last allowed cycle still wins over the abort.
        if (mul_done) begin
          prod_d      = mul_product;
          err_d       = 1'b0;
          rsp_valid_d = owner_oh;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          prod_d      = '0;
          err_d       = 1'b1;
          rsp_valid_d = owner_oh;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          rr_ptr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      mul_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      mul_start_q <= mul_start_d;
    end
  end

  // The accept strobe must coincide with the cycle the requester still holds
  // valid, so it is decoded from the current state; reset forces it low.
  assign req_ready   = (state_q == ST_IDLE && !rst) ? grant : '0;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = prod_q;
  assign rsp_err     = err_q;
  assign mul_start   = mul_start_q;
  assign mul_a       = (state_q == ST_ISSUE || state_q == ST_WAIT) ? op_a_q : '0;
  assign mul_b       = (state_q == ST_ISSUE || state_q == ST_WAIT) ? op_b_q : '0;
  assign busy        = (state_q != ST_IDLE);

endmodule : mult_share_arbiter

// File: tb/tb_mult_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mult_share_arbiter
// Self-checking bench: a cycle model of the job FSM plus a scoreboard of
// granted jobs; a behavioural multiplier answers mul_start after mul_lat
// cycles. Inputs change 1 ns after the rising edge, outputs are sampled on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_mult_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [2*W-1:0]   rsp_product, mul_product;
  logic             rsp_err, mul_start, mul_done, busy;
  logic [W-1:0]     mul_a, mul_b;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NUM_REQ(N), .OP_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_done(mul_done), .busy(busy)
  );

  // Operands per requester, packed onto the DUT buses.
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  bit           again_en [N];
  logic [W-1:0] again_a [N];
  logic [W-1:0] again_b [N];

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  typedef struct {
    int             idx;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } job_t;

  job_t sb[$];
  int   gord[$];

  // Model state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP.
  int           m_phase, m_ptr, m_owner, m_wcnt;
  bit           m_tout;
  logic [N-1:0] clr_mask;
  int           cyc, grant_cyc, last_lat, rsp_cnt;
  bit           lat_arm;
  logic [2*W-1:0] last_prod;
  logic [2*W-1:0] prod_by [N];
  logic         last_err;

  // Behavioural multiplier.
  bit           done_en;
  int           mul_lat;
  bit           spur, spur_now, mb_busy;
  int           mcnt;
  logic [W-1:0] ma, mb;

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_owner = 0; m_wcnt = 0; m_tout = 0;
    clr_mask = '0; lat_arm = 0;
    sb.delete(); gord.delete();
    mb_busy = 0; spur_now = 0; mul_done = 1'b0; mul_product = '0;
  endtask

  task automatic monitor();
    logic [N-1:0] exp_rdy, exp_rv;
    int           w;
    job_t         j;
    exp_rdy = '0;
    exp_rv  = '0;
    w       = -1;
    if (m_phase == 0) begin
      w = rr_pick(req_valid, m_ptr);
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    check("req_ready", req_ready, exp_rdy);
    check("busy", busy, m_phase != 0);
    check("mul_start", mul_start, m_phase == 1);
    if (m_phase == 1 || m_phase == 2) check("mul_ops", {mul_a, mul_b}, {sb[0].a, sb[0].b});
    else                              check("mul_ops", {mul_a, mul_b}, '0);
    if (m_phase == 3) exp_rv[m_owner] = 1'b1;
    check("rsp_valid", rsp_valid, exp_rv);
    if (m_phase == 3) begin
      check("rsp_data", {rsp_err, rsp_product}, {m_tout, m_tout ? '0 : sb[0].prod});
      if (lat_arm) begin last_lat = cyc - grant_cyc; lat_arm = 0; end
    end

    // Multiplier sees the start pulse as driven by the DUT.
    if (mul_start) begin mb_busy = 1; mcnt = mul_lat; ma = mul_a; mb = mul_b; end

    case (m_phase)
      0: if (w >= 0) begin
        j.idx = w; j.a = op_a[w]; j.b = op_b[w];
        j.prod = (2*W)'(op_a[w]) * (2*W)'(op_b[w]);
        sb.push_back(j);
        gord.push_back(w);
        m_owner = w; clr_mask[w] = 1'b1; m_phase = 1;
        grant_cyc = cyc; lat_arm = 1; spur_now = spur; spur = 0;
      end
      1: begin m_phase = 2; m_wcnt = 0; end
      2: if (mul_done)            begin m_phase = 3; m_tout = 0; end
         else if (m_wcnt == TO-1) begin m_phase = 3; m_tout = 1; end
         else                       m_wcnt++;
      3: if (rsp_ready[m_owner]) begin
        j = sb.pop_front();
        check("rsp_final", {rsp_err, rsp_product}, {m_tout, m_tout ? '0 : j.prod});
        last_prod = rsp_product; last_err = rsp_err; prod_by[m_owner] = rsp_product;
        rsp_cnt++;
        m_ptr = (m_owner + 1) % N;
        m_phase = 0;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (clr_mask[i]) begin
        if (again_en[i]) begin
          op_a[i] = again_a[i]; op_b[i] = again_b[i]; again_en[i] = 0;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    clr_mask = '0;
    mul_done = 1'b0;
    mul_product = '0;
    if (spur_now) begin
      // Completion during ISSUE must be ignored by the DUT.
      mul_done = 1'b1; mul_product = 32'hDEAD_BEEF; spur_now = 0;
    end else if (mb_busy) begin
      if (mcnt == 0) begin
        if (done_en) begin mul_done = 1'b1; mul_product = (2*W)'(ma) * (2*W)'(mb); end
        mb_busy = 0;
      end else begin
        mcnt--;
      end
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n = 0;
    while (rsp_cnt < target && n < budget) begin tick(); n++; end
    check("rsp_budget", rsp_cnt >= target, 1'b1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int base, hold, n;
    int ord0 [5];
    rst = 1'b1; req_valid = '1; rsp_ready = '1;
    done_en = 1; mul_lat = 0; spur = 0; cyc = 0; rsp_cnt = 0;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; again_en[i] = 0; end
    model_reset();

    // Reset state, with requests present so the accept strobe is exercised.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {req_ready, rsp_valid, rsp_err, mul_start, busy}, '0);
    check("rst_data", {mul_a, mul_b, rsp_product}, '0);
    req_valid = '0;
    rst = 1'b0;

    // Single job 3*5 with a spurious completion during ISSUE.
    op_a[0] = 16'd3; op_b[0] = 16'd5; spur = 1; req_valid[0] = 1'b1;
    wait_rsp(1, 50);
    check("t1_product", last_prod, 32'd15);
    check("t1_err", last_err, 1'b0);
    check("t1_latency", last_lat, 3);

    // Contention from reset: order 0,1,2,3,0, each with its own product.
    apply_reset();
    op_a[0] = 16'h0002; op_b[0] = 16'h0007;
    op_a[1] = 16'h1234; op_b[1] = 16'h0010;
    op_a[2] = 16'h00FF; op_b[2] = 16'h0101;
    op_a[3] = 16'hFFFF; op_b[3] = 16'hFFFF;
    again_en[0] = 1; again_a[0] = 16'h8000; again_b[0] = 16'h0002;
    req_valid = '1;
    base = rsp_cnt;
    wait_rsp(base + 5, 100);
    ord0 = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) check("t2_order", (gord.size() > i) ? gord[i] : -1, ord0[i]);
    check("t2_prod3", prod_by[3], 32'hFFFE_0001);
    check("t2_prod0", prod_by[0], 32'h0001_0000);

    // Backpressure on requester 1; non-owner ready bits stay high.
    gord.delete();
    op_a[1] = 16'h0101; op_b[1] = 16'h0202;
    op_a[2] = 16'h0003; op_b[2] = 16'h0003;
    rsp_ready = 4'b1101;
    req_valid[1] = 1'b1; req_valid[2] = 1'b1;
    base = rsp_cnt;
    n = 0;
    while (m_phase != 3 && n < 20) begin tick(); n++; end
    check("t3_reach_resp", m_phase, 3);
    hold = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid == 4'b0010 && rsp_product == 32'h0002_0402 && req_ready == '0) hold++;
    end
    check("t3_hold", hold, 10);
    rsp_ready = '1;
    wait_rsp(base + 2, 60);
    check("t3_order1", (gord.size() > 0) ? gord[0] : -1, 1);
    check("t3_order2", (gord.size() > 1) ? gord[1] : -1, 2);

    // Timeout on requester 3, then requester 0 served normally.
    gord.delete();
    done_en = 0;
    op_a[3] = 16'h1111; op_b[3] = 16'h2222;
    op_a[0] = 16'd7;    op_b[0] = 16'd6;
    req_valid[3] = 1'b1; req_valid[0] = 1'b1;
    base = rsp_cnt;
    wait_rsp(base + 1, TO + 20);
    done_en = 1;
    check("t4_err", last_err, 1'b1);
    check("t4_prod", last_prod, '0);
    check("t4_latency", last_lat, TO + 2);
    wait_rsp(base + 2, 40);
    check("t4_next", (gord.size() > 1) ? gord[1] : -1, 0);
    check("t4_next_prod", last_prod, 32'd42);
    check("t4_next_err", last_err, 1'b0);

    // Reset while WAITing on requester 2; next grant must come from 0.
    mul_lat = 20;
    op_a[2] = 16'd9; op_b[2] = 16'd9;
    req_valid[2] = 1'b1;
    n = 0;
    while (m_phase != 2 && n < 20) begin tick(); n++; end
    repeat (3) tick();
    check("t5_in_wait", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ctrl", {req_ready, rsp_valid, rsp_err, mul_start, busy}, '0);
    check("t5_rst_data", {mul_a, mul_b, rsp_product}, '0);
    model_reset();
    req_valid = '0;
    mul_lat = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    op_a[0] = 16'd4;  op_b[0] = 16'd4;
    op_a[2] = 16'd10; op_b[2] = 16'd10;
    req_valid[0] = 1'b1; req_valid[2] = 1'b1;
    base = rsp_cnt;
    wait_rsp(base + 2, 40);
    check("t5_first", (gord.size() > 0) ? gord[0] : -1, 0);
    check("t5_second", (gord.size() > 1) ? gord[1] : -1, 2);
    check("t5_last_prod", last_prod, 32'd100);
    repeat (2) tick();
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mult_share_arbiter
